// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory-port arbiter.
// rr_pick works on a fixed MAX_NREQ-wide vector so any NREQ up to 8 can use it.
package mem_arb_pkg;

  localparam int MAX_NREQ = 8;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WR,
    OP_RD
  } arb_op_e;

  // Tag width for n requesters; at least one bit so the FIFO never collapses to zero width.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot of the first set bit of req at or above ptr, wrapping modulo n.
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                                  input logic [2:0]          ptr,
                                                  input int                  n);
    logic [MAX_NREQ-1:0] gnt;
    logic                found;
    int                  idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order tag FIFO remembering which requester issued each outstanding read.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module mem_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = store_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; an entry is only read while count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port among NREQ requesters, one operation per cycle.
// Read returns are steered back to their issuer through an in-order tag FIFO.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ALEN    = 32,
  parameter int DLEN    = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_wen,
  input  logic [NREQ*ALEN-1:0] req_waddr,
  input  logic [NREQ*DLEN-1:0] req_wdata,
  output logic [NREQ-1:0]      req_wgnt,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ*ALEN-1:0] req_raddr,
  output logic [NREQ-1:0]      req_rgnt,
  output logic [NREQ-1:0]      req_rvalid,
  output logic [DLEN-1:0]      req_rdata,
  output logic                 mem_wen,
  output logic [ALEN-1:0]      mem_waddr,
  output logic [DLEN-1:0]      mem_wdata,
  output logic                 mem_ren,
  output logic [ALEN-1:0]      mem_raddr,
  input  logic                 mem_rvalid,
  input  logic [DLEN-1:0]      mem_rdata,
  output logic                 err_orphan
);

  localparam int IW = idw(NREQ);
  localparam int CW = $clog2(MAX_OUT) + 1;

  logic [2:0]          ptr_q, ptr_d;
  logic                err_q, err_d;
  logic [MAX_NREQ-1:0] elig, pick;
  logic [IW-1:0]       sel, head;
  arb_op_e             op;
  logic                rd_ok, push, pop, fifo_full, fifo_empty;
  logic [CW-1:0]       count;

  // A pop in this cycle frees a slot, so a read may be granted even when the FIFO is full.
  always_comb begin
    rd_ok = !fifo_full || mem_rvalid;
    elig  = '0;
    for (int i = 0; i < NREQ; i++) elig[i] = req_wen[i] | (req_ren[i] & rd_ok);
    pick = rr_pick(elig, ptr_q, NREQ);
    sel  = '0;
    for (int i = 0; i < MAX_NREQ; i++) if (pick[i]) sel = IW'(i);
    if (pick == '0)        op = OP_NONE;
    else if (req_wen[sel]) op = OP_WR;
    else                   op = OP_RD;
  end

  always_comb begin
    req_wgnt  = '0;
    req_rgnt  = '0;
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_ren   = 1'b0;
    mem_raddr = '0;
    unique case (op)
      OP_WR: begin
        req_wgnt[sel] = 1'b1;
        mem_wen       = 1'b1;
        mem_waddr     = req_waddr[int'(sel)*ALEN +: ALEN];
        mem_wdata     = req_wdata[int'(sel)*DLEN +: DLEN];
      end
      OP_RD: begin
        req_rgnt[sel] = 1'b1;
        mem_ren       = 1'b1;
        mem_raddr     = req_raddr[int'(sel)*ALEN +: ALEN];
      end
      default: ;
    endcase
  end

  assign push = (op == OP_RD);
  assign pop  = mem_rvalid && !fifo_empty;

  always_comb begin
    req_rvalid = '0;
    req_rdata  = '0;
    if (pop) begin
      req_rvalid[head] = 1'b1;
      req_rdata        = mem_rdata;
    end
    ptr_d = ptr_q;
    if (op != OP_NONE) ptr_d = (int'(sel) == NREQ - 1) ? 3'd0 : 3'(sel) + 3'd1;
    err_d = err_q | (mem_rvalid && (count == '0));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  assign err_orphan = err_q;

  mem_arb_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (IW)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios with literal expectations, plus a
// queue-based reference model compared against every output on every falling edge.
module tb_mem_rr_arbiter;

  localparam int NREQ    = 2;
  localparam int ALEN    = 32;
  localparam int DLEN    = 32;
  localparam int MAX_OUT = 4;

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_wen;
  logic [NREQ*ALEN-1:0] req_waddr;
  logic [NREQ*DLEN-1:0] req_wdata;
  logic [NREQ-1:0]      req_wgnt;
  logic [NREQ-1:0]      req_ren;
  logic [NREQ*ALEN-1:0] req_raddr;
  logic [NREQ-1:0]      req_rgnt;
  logic [NREQ-1:0]      req_rvalid;
  logic [DLEN-1:0]      req_rdata;
  logic                 mem_wen;
  logic [ALEN-1:0]      mem_waddr;
  logic [DLEN-1:0]      mem_wdata;
  logic                 mem_ren;
  logic [ALEN-1:0]      mem_raddr;
  logic                 mem_rvalid;
  logic [DLEN-1:0]      mem_rdata;
  logic                 err_orphan;

  int checks = 0;
  int errors = 0;

  mem_rr_arbiter #(
    .NREQ(NREQ), .ALEN(ALEN), .DLEN(DLEN), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_wen(req_wen), .req_waddr(req_waddr), .req_wdata(req_wdata), .req_wgnt(req_wgnt),
    .req_ren(req_ren), .req_raddr(req_raddr), .req_rgnt(req_rgnt),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pointer, queue of issuer tags, sticky orphan flag.
  int      m_ptr = 0;
  int      m_q[$];
  bit      m_err = 1'b0;

  always @(negedge clk) begin : cmp_proc
    int              win;
    int              idx;
    bit              rd_ok;
    logic [NREQ-1:0] e_wg, e_rg, e_rv;
    logic            e_mwen, e_mren;
    logic [ALEN-1:0] e_waddr, e_raddr;
    logic [DLEN-1:0] e_wdata, e_rdata;
    if (!rstn) begin
      m_ptr = 0;
      m_q.delete();
      m_err = 1'b0;
    end
    rd_ok = (m_q.size() < MAX_OUT) || mem_rvalid;
    win   = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (win < 0 && (req_wen[idx] || (req_ren[idx] && rd_ok))) win = idx;
    end
    e_wg = '0; e_rg = '0; e_rv = '0;
    e_mwen = 1'b0; e_mren = 1'b0;
    e_waddr = '0; e_wdata = '0; e_raddr = '0; e_rdata = '0;
    if (win >= 0 && req_wen[win]) begin
      e_wg[win] = 1'b1;
      e_mwen    = 1'b1;
      e_waddr   = req_waddr[win*ALEN +: ALEN];
      e_wdata   = req_wdata[win*DLEN +: DLEN];
    end else if (win >= 0) begin
      e_rg[win] = 1'b1;
      e_mren    = 1'b1;
      e_raddr   = req_raddr[win*ALEN +: ALEN];
    end
    if (mem_rvalid && m_q.size() > 0) begin
      e_rv[m_q[0]] = 1'b1;
      e_rdata      = mem_rdata;
    end
    check("cmp_wgnt",   req_wgnt,   e_wg);
    check("cmp_rgnt",   req_rgnt,   e_rg);
    check("cmp_mwen",   mem_wen,    e_mwen);
    check("cmp_mren",   mem_ren,    e_mren);
    check("cmp_waddr",  mem_waddr,  e_waddr);
    check("cmp_wdata",  mem_wdata,  e_wdata);
    check("cmp_raddr",  mem_raddr,  e_raddr);
    check("cmp_rvalid", req_rvalid, e_rv);
    check("cmp_rdata",  req_rdata,  e_rdata);
    check("cmp_err",    err_orphan, m_err);
    if (rstn) begin
      if (mem_rvalid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (win >= 0 && !req_wen[win]) m_q.push_back(win);
      if (win >= 0) m_ptr = (win + 1) % NREQ;
    end
  end

  typedef struct {
    logic [1:0] wen;
    logic [1:0] ren;
    logic       rv;
  } vec_t;

  vec_t mix[12];

  initial begin
    rstn       = 1'b0;
    req_wen    = '0; req_ren = '0;
    req_waddr  = '0; req_wdata = '0; req_raddr = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_err",  err_orphan, 1'b0);
    check("rst_gnt",  {req_wgnt, req_rgnt, req_rvalid}, 6'b0);
    rstn = 1'b1;

    // 1: two writers alternate starting from requester 0
    req_wen = 2'b11;
    req_waddr[0 +: 32] = 32'h10; req_waddr[32 +: 32] = 32'h20;
    req_wdata[0 +: 32] = 32'hA0; req_wdata[32 +: 32] = 32'hB0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t1_waddr", mem_waddr, (k % 2 == 0) ? 32'h10 : 32'h20);
      check("t1_wgnt",  req_wgnt,  (k % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
    end
    req_wen = '0;

    // 2: write before read within requester 0
    req_wen = 2'b01; req_ren = 2'b01;
    req_waddr[0 +: 32] = 32'h40; req_raddr[0 +: 32] = 32'h40; req_wdata[0 +: 32] = 32'hD0;
    #1;
    check("t2_wgnt", req_wgnt, 2'b01);
    check("t2_mren_first", mem_ren, 1'b0);
    cyc();
    req_wen = '0;
    #1;
    check("t2_rgnt", req_rgnt, 2'b01);
    check("t2_raddr", mem_raddr, 32'h40);
    cyc();
    req_ren = '0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    #1;
    check("t2_rvalid", req_rvalid, 2'b01);
    check("t2_rdata", req_rdata, 32'h1234);
    cyc();
    mem_rvalid = 1'b0;

    // 3: four reads fill the FIFO, the fifth waits for the first return (latency 6)
    req_ren = 2'b10; req_raddr[32 +: 32] = 32'h80;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t3_rgnt", req_rgnt, (k < 4) ? 2'b10 : 2'b00);
      cyc();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h3000;
    #1;
    check("t3_rgnt_resume", req_rgnt, 2'b10);
    check("t3_rvalid", req_rvalid, 2'b10);
    cyc();
    req_ren = '0;
    for (int j = 0; j < 4; j++) begin
      mem_rdata = 32'h3001 + j;
      #1;
      check("t3_drain_rvalid", req_rvalid, 2'b10);
      cyc();
    end
    mem_rvalid = 1'b0;

    // 4: returns routed in issue order
    req_ren = 2'b01; req_raddr[0 +: 32] = 32'h100;
    #1;
    check("t4_rgnt0", req_rgnt, 2'b01);
    cyc();
    req_ren = 2'b10; req_raddr[32 +: 32] = 32'h200;
    #1;
    check("t4_raddr1", mem_raddr, 32'h200);
    cyc();
    req_ren = '0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA;
    #1;
    check("t4_rv_a", req_rvalid, 2'b01);
    check("t4_rd_a", req_rdata, 32'hAAAA);
    cyc();
    mem_rdata = 32'hBBBB;
    #1;
    check("t4_rv_b", req_rvalid, 2'b10);
    check("t4_rd_b", req_rdata, 32'hBBBB);
    cyc();
    mem_rvalid = 1'b0;

    // 5: orphan return is sticky
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    #1;
    check("t5_rvalid", req_rvalid, 2'b00);
    cyc();
    mem_rvalid = 1'b0;
    #1;
    check("t5_err_set", err_orphan, 1'b1);
    repeat (3) cyc();
    check("t5_err_hold", err_orphan, 1'b1);

    // 6: async reset with two reads outstanding and the pointer at 1
    rstn = 1'b0;
    #1;
    check("t6_err_clr", err_orphan, 1'b0);
    cyc();
    rstn = 1'b1;
    req_ren = 2'b01; req_raddr[0 +: 32] = 32'h300;
    cyc();
    req_ren = 2'b10; req_raddr[32 +: 32] = 32'h310;
    cyc();
    req_ren = '0; req_wen = 2'b11;
    cyc();
    #2;
    rstn = 1'b0; req_wen = '0;
    #1;
    check("t6_outs_zero", {req_wgnt, req_rgnt, req_rvalid, mem_wen, mem_ren, err_orphan}, 9'b0);
    repeat (2) cyc();
    rstn = 1'b1; req_wen = 2'b11;
    #1;
    check("t6_ptr_zero", req_wgnt, 2'b01);
    cyc();
    req_wen = '0; mem_rvalid = 1'b1;
    #1;
    check("t6_rvalid", req_rvalid, 2'b00);
    cyc();
    mem_rvalid = 1'b0;
    #1;
    check("t6_err", err_orphan, 1'b1);

    // 7: mixed contention; the per-cycle model does the checking
    req_waddr[0 +: 32] = 32'h500; req_waddr[32 +: 32] = 32'h510;
    req_wdata[0 +: 32] = 32'h11;  req_wdata[32 +: 32] = 32'h22;
    req_raddr[0 +: 32] = 32'h600; req_raddr[32 +: 32] = 32'h610;
    mix[0]  = '{2'b01, 2'b10, 1'b0}; mix[1]  = '{2'b01, 2'b10, 1'b0};
    mix[2]  = '{2'b00, 2'b11, 1'b0}; mix[3]  = '{2'b11, 2'b11, 1'b0};
    mix[4]  = '{2'b10, 2'b01, 1'b1}; mix[5]  = '{2'b00, 2'b11, 1'b0};
    mix[6]  = '{2'b00, 2'b11, 1'b0}; mix[7]  = '{2'b00, 2'b11, 1'b1};
    mix[8]  = '{2'b00, 2'b00, 1'b1}; mix[9]  = '{2'b00, 2'b00, 1'b1};
    mix[10] = '{2'b00, 2'b00, 1'b1}; mix[11] = '{2'b00, 2'b00, 1'b1};
    for (int k = 0; k < 12; k++) begin
      req_wen = mix[k].wen; req_ren = mix[k].ren;
      mem_rvalid = mix[k].rv; mem_rdata = 32'h7000 + k;
      cyc();
    end
    req_wen = '0; req_ren = '0; mem_rvalid = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one memory port (write strobe/address/data, read strobe/address, read-valid/data return) between NREQ requesters.
- Typical use: several AXI4-Lite-to-memory bridges driving one RAM.
- Round-robin grant per cycle: at most one memory operation (write or read) per cycle.
- An in-order tag FIFO routes each read return to the requester that issued it.

Parameters:
- NREQ, 2: number of requesters (2..8).
- ALEN, 32: memory address width.
- DLEN, 32: data width.
- MAX_OUT, 4: maximum outstanding reads (power of two, ≥2).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_wen  in  NREQ  per-requester write request, held until granted
- req_waddr  in  NREQ*ALEN  packed write addresses, requester i at [i*ALEN+:ALEN]
- req_wdata  in  NREQ*DLEN  packed write data
- req_wgnt  out  NREQ  write grant, one-hot or zero, combinational
- req_ren  in  NREQ  read request, held until granted
- req_raddr  in  NREQ*ALEN  packed read addresses
- req_rgnt  out  NREQ  read grant, one-hot or zero, combinational
- req_rvalid  out  NREQ  read return valid, one-hot or zero
- req_rdata  out  DLEN  read return data, broadcast to all requesters
- mem_wen  out  1  memory write strobe
- mem_waddr  out  ALEN  memory write address
- mem_wdata  out  DLEN  memory write data
- mem_ren  out  1  memory read strobe
- mem_raddr  out  ALEN  memory read address
- mem_rvalid  in  1  memory read return valid
- mem_rdata  in  DLEN  memory read return data
- err_orphan  out  1  sticky flag: mem_rvalid seen with no read outstanding

Behaviour:
- Reset (async assert, sync deassert to clk): round-robin pointer = 0, tag FIFO empty, count = 0, err_orphan = 0.
- Combinational outputs are 0 whenever no request is eligible.
- Eligibility per requester i:
  - Write eligible if req_wen[i].
  - Read eligible if req_ren[i] && !req_wen[i] && rd_ok, where rd_ok = (count < MAX_OUT) || mem_rvalid.
  - Write-before-read within a requester preserves that requester's ordering.
- Selection: first eligible requester scanning from pointer upward, mod NREQ.
- Grant is combinational, in the same cycle as the memory strobe:
  - Write: req_wgnt[i] = 1, mem_wen = 1, mem_waddr/mem_wdata = requester i's fields.
  - Read: req_rgnt[i] = 1, mem_ren = 1, mem_raddr = requester i's address.
  - Never mem_wen and mem_ren in the same cycle; never more than one grant bit set.
- Requesters sample the grant at the clock edge and may drop or change their request the next cycle.
- Pointer: on any grant to i, pointer <= (i+1) mod NREQ. No grant: pointer holds.
- Tag FIFO:
  - Depth MAX_OUT, entry width $clog2(NREQ).
  - Push i on a read grant; pop on mem_rvalid.
  - Push and pop in the same cycle: count unchanged, allowed when full.
  - Pointers wrap mod MAX_OUT.
- Read return: mem_rvalid && count > 0 → req_rvalid[head] = 1 and req_rdata = mem_rdata in the same cycle, combinational.
- Orphan return: mem_rvalid && count == 0 → req_rvalid = 0, nothing popped, err_orphan <= 1 until reset.
- Memory latency is arbitrary (≥1 cycle); returns are in order.
- Reset mid-operation: outstanding tags are discarded; later returns raise err_orphan.
- Fairness: a continuously requesting requester is granted within NREQ cycles, except that reads stall while the FIFO is full without a pop.
- Request inputs must be stable while asserted and ungranted; violations are not checked.

Decomposition:
- Package mem_arb_pkg:
  - IDW = $clog2(NREQ) helper function.
  - Typedef arb_op_e {OP_NONE, OP_WR, OP_RD}.
  - Function rr_pick(req, ptr) returning a one-hot vector.
- Sub-module mem_arb_tag_fifo:
  - Synchronous FIFO with push, pop, din, dout, count, full, empty.
  - Same-cycle push/pop when full is permitted.

Test Plan:
1. NREQ=2; req_wen=2'b11 held 4 cycles, addrs 0x10/0x20 → mem_waddr sequence 0x10, 0x20, 0x10, 0x20; wgnt alternates 01, 10, 01, 10.
2. Requester 0 holds wen and ren simultaneously, addr 0x40 → write granted first cycle, read granted next cycle; tag 0 pushed.
3. Requester 1 issues 4 reads, memory latency 6 cycles, no returns yet → 5th read not granted (count=4); grant resumes the cycle the first mem_rvalid arrives.
4. Reads from requester 0 then requester 1; returns 0xAAAA then 0xBBBB → req_rvalid=01 with 0xAAAA, then 10 with 0xBBBB.
5. mem_rvalid pulse with FIFO empty → req_rvalid=0, err_orphan=1 and stays 1 until rstn asserted.
6. rstn asserted asynchronously mid-burst with 2 reads outstanding → all outputs 0 immediately, count=0, pointer=0; the later mem_rvalid sets err_orphan.
